// File: rtl/wash_phase_timer.sv
// wash_phase_timer: times the wash/drain/spin/alarm phases of the washer controller and raises a level time-up flag per phase
// Ports: clk, reset (async, active-high), state_in[2:0] (Gray-coded controller state);
//        wash/water/dewater/alarm (time-up flags), remain_sec[7:0] (seconds left), sec_tick (second boundary pulse).
module wash_phase_timer #(
  parameter int         CLK_DIV     = 50_000_000,
  parameter logic [7:0] WASH_SEC    = 8'd30,
  parameter logic [7:0] WATER_SEC   = 8'd20,
  parameter logic [7:0] DEWATER_SEC = 8'd25,
  parameter logic [7:0] ALARM_SEC   = 8'd5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state_in,
  output logic       wash,
  output logic       water,
  output logic       dewater,
  output logic       alarm,
  output logic [7:0] remain_sec,
  output logic       sec_tick
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  logic [2:0] prev_state;
  logic [DW-1:0] div_cnt, div_n;
  logic [7:0] sec_cnt, sec_n, dur;
  logic [3:0] flags, flags_n, code_flag;
  logic expired, expired_n, tick_n, entry, timed, wrap, count, zero, fire;
  always_comb begin
    dur = state_in == 3'b011 ? WASH_SEC :
          state_in == 3'b010 ? WATER_SEC :
          state_in == 3'b110 ? DEWATER_SEC :
          state_in == 3'b100 ? ALARM_SEC : 8'd0;
    code_flag = {state_in == 3'b100, state_in == 3'b110, state_in == 3'b010, state_in == 3'b011};
    timed = |code_flag;
    entry = state_in != prev_state;
    wrap = div_cnt == DIV_MAX;
    count = timed && !entry && !expired;
    zero = sec_cnt == 8'd0;
    // a zero-length phase expires on the first edge after entry without ticking
    fire = count && (zero || (wrap && sec_cnt == 8'd1));
    tick_n = count && !zero && wrap;
    div_n = entry ? '0 : (count && !zero) ? (wrap ? '0 : div_cnt + DW'(1)) : div_cnt;
    sec_n = entry ? dur : tick_n ? sec_cnt - 8'd1 : sec_cnt;
    expired_n = entry ? 1'b0 : expired | fire;
    flags_n = entry ? 4'd0 : fire ? code_flag : flags;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_state <= 3'b000;
      div_cnt <= '0;
      sec_cnt <= 8'd0;
      expired <= 1'b0;
      flags <= 4'd0;
      sec_tick <= 1'b0;
    end else begin
      prev_state <= state_in;
      div_cnt <= div_n;
      sec_cnt <= sec_n;
      expired <= expired_n;
      flags <= flags_n;
      sec_tick <= tick_n;
    end
  end
  assign {alarm, dewater, water, wash} = flags;
  assign remain_sec = sec_cnt;
endmodule

// File: tb/tb_wash_phase_timer.sv
// tb_wash_phase_timer: randomized scoreboard bench for wash_phase_timer against an elapsed-time reference model
module tb_wash_phase_timer;
  localparam int DIV = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] state_in = 3'b000;
  logic wash, water, dewater, alarm, sec_tick;
  logic [7:0] remain_sec;
  int tests = 0, fails = 0, el = 0, cyc = 0;
  logic [2:0] mprev = 3'b000;
  logic [12:0] exp_q[$];
  logic [2:0] codes[8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b111};
  bit done = 0;

  wash_phase_timer #(.CLK_DIV(DIV), .WASH_SEC(8'd3), .WATER_SEC(8'd2), .DEWATER_SEC(8'd1), .ALARM_SEC(8'd0)) dut (
    .clk(clk), .reset(reset), .state_in(state_in), .wash(wash), .water(water),
    .dewater(dewater), .alarm(alarm), .remain_sec(remain_sec), .sec_tick(sec_tick));

  always #5 clk = ~clk;

  function automatic logic [12:0] model(input logic [2:0] s, input int e);
    int dur, lim;
    logic [3:0] f;
    f = {s == 3'b011, s == 3'b010, s == 3'b110, s == 3'b100};
    dur = s == 3'b011 ? 3 : s == 3'b010 ? 2 : s == 3'b110 ? 1 : 0;
    if (f == 4'd0) return 13'd0;
    lim = dur == 0 ? 1 : dur * DIV;
    return {(e >= lim) ? f : 4'd0,
            e > 0 && e % DIV == 0 && e <= dur * DIV,
            8'(dur - ((e / DIV) < dur ? e / DIV : dur))};
  endfunction

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got flags=%b tick=%b remain=%0d, expected flags=%b tick=%b remain=%0d",
               name, $time, got[12:9], got[8], got[7:0], exp[12:9], exp[8], exp[7:0]);
    end
  endtask

  task automatic step(input logic [2:0] s);
    @(negedge clk);
    reset = 1'b0;
    state_in = s;
    if (s != mprev) el = 0; else if (el < 100000) el++;
    mprev = s;
    exp_q.push_back(model(s, el));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst", {wash, water, dewater, alarm, sec_tick, remain_sec}, 13'd0);
    mprev = 3'b000;
    el = 0;
    exp_q.push_back(13'd0);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) check("cycle", {wash, water, dewater, alarm, sec_tick, remain_sec}, exp_q.pop_front());
  end

  initial begin
    #2;
    check("reset_state", {wash, water, dewater, alarm, sec_tick, remain_sec}, 13'd0);
    repeat (2) do_reset();
    repeat (2) step(3'b000);
    repeat (21) step(3'b011);
    repeat (3) step(3'b001);
    repeat (13) step(3'b011);
    repeat (9) step(3'b010);
    repeat (5) step(3'b110);
    repeat (2) step(3'b100);
    repeat (3) step(3'b000);
    repeat (6) step(3'b011);
    repeat (3) step(3'b000);
    repeat (6) step(3'b011);
    do_reset();
    repeat (14) step(3'b011);
    repeat (3) step(3'b101);
    repeat (3) step(3'b111);
    repeat (6) step(3'b110);
    repeat (14) step(3'b011);
    repeat (3) step(3'b010);
    for (int i = 0; i < 150; i++) begin
      logic [2:0] s;
      if ($urandom_range(0, 9) == 0) do_reset();
      s = codes[$urandom_range(0, 7)];
      repeat ($urandom_range(1, 16)) step(s);
    end
    repeat (2) @(negedge clk);
    check("queue_drained", 13'(exp_q.size()), 13'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
